spi_regbank: RTL and testbench

Parametrised SPI register bank: successor to the fixed eight-register SPI write/readout path. Decodes a bit-serial frame (R/W flag, address, then a burst of data words) clocked by `sclk`. Writes into, or reads out of, a bank of `NUM_REGS` registers of `DATA_W` bits, with auto-incrementing burst addressing and per-register read-only mapping. Per-register write/read strobes let downstream logic react to individual accesses.

---
 rtl/spi_regbank.sv | 167 ++++++++++++++++
 tb/tb_spi_regbank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank.sv
// SPI register bank: decodes R/W + address header, then bursts data words
// into or out of NUM_REGS registers with auto-increment and read-only mapping.
module spi_regbank #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                         sclk,
    input  logic                         rstn,
    input  logic                         csn,
    input  logic                         mosi,
    output logic                         miso,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic [NUM_REGS-1:0]          rd_strobe,
    output logic                         frame_err,
    output logic                         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RD   = 2'd3;

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              rw;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              frame_rst_n;
    logic [ADDR_W-1:0] hdr_addr;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic [NUM_REGS-1:0] rd_hit;
    logic [NUM_REGS-1:0] wr_hit;
    logic              hdr_last;
    logic              word_last;
    logic              wr_commit;
    logic              rd_load;
    logic              unused_ro;

    // Frame logic is held in IDLE while csn is high; register contents are not.
    assign frame_rst_n = rstn & ~csn;

    assign hdr_addr  = {waddr[ADDR_W-2:0], mosi};
    assign hdr_last  = (state == HDR) && (cnt == CNT_W'(ADDR_W - 1));
    assign word_last = (cnt == CNT_W'(DATA_W - 1));
    assign wr_commit = (state == WR) && word_last;
    assign rd_load   = (hdr_last && rw) || ((state == RD) && word_last);
    assign load_addr = (state == HDR) ? hdr_addr : waddr + ADDR_W'(1);
    assign wr_word   = {sr[DATA_W-2:0], mosi};
    assign busy      = (state != IDLE);

    always_comb begin
        rd_hit  = '0;
        wr_hit  = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (load_addr == ADDR_W'(i)) begin
                rd_hit[i] = 1'b1;
                rd_word   = RO_MASK[i] ? ro_data[i*DATA_W +: DATA_W] : regs[i];
            end
            if ((waddr == ADDR_W'(i)) && !RO_MASK[i]) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rw        <= 1'b0;
            waddr     <= '0;
            sr        <= '0;
            wr_strobe <= '0;
            rd_strobe <= '0;
        end else begin
            wr_strobe <= wr_commit ? wr_hit : '0;
            rd_strobe <= rd_load ? rd_hit : '0;
            case (state)
                IDLE: begin
                    rw    <= mosi;
                    cnt   <= '0;
                    state <= HDR;
                end
                HDR: begin
                    waddr <= hdr_addr;
                    if (hdr_last) begin
                        cnt   <= '0;
                        state <= rw ? RD : WR;
                        if (rw) begin
                            sr <= rd_word;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR: begin
                    sr <= wr_word;
                    if (word_last) begin
                        cnt   <= '0;
                        waddr <= waddr + ADDR_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (word_last) begin
                        cnt   <= '0;
                        waddr <= load_addr;
                        sr    <= rd_word;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        sr  <= {sr[DATA_W-2:0], 1'b0};
                    end
                end
            endcase
        end
    end

    // Storage, error flag and miso survive csn so they persist between frames.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            frame_err <= 1'b0;
            miso      <= 1'b0;
        end else begin
            if (wr_commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_hit[i]) begin
                        regs[i] <= wr_word;
                    end
                end
            end

            if ((state == IDLE) && !csn) begin
                frame_err <= 1'b0;
            end else if ((wr_commit && !(|wr_hit)) || (rd_load && !(|rd_hit))) begin
                frame_err <= 1'b1;
            end

            if (rd_load) begin
                miso <= rd_word[DATA_W-1];
            end else if (state == RD) begin
                miso <= sr[DATA_W-2];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        assign reg_q[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs[g];
    end

    assign unused_ro = ^ro_data;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed self-checking bench for spi_regbank with register 15 mapped read-only.
module tb_spi_regbank;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;

    logic                       sclk = 1'b0;
    logic                       rstn;
    logic                       csn;
    logic                       mosi;
    logic                       miso;
    logic [NUM_REGS*DATA_W-1:0] ro_data;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic [NUM_REGS-1:0]        rd_strobe;
    logic                       frame_err;
    logic                       busy;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q;
    logic [7:0]   rword;

    spi_regbank #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RO_MASK (16'h8000)
    ) dut (
        .sclk     (sclk),
        .rstn     (rstn),
        .csn      (csn),
        .mosi     (mosi),
        .miso     (miso),
        .ro_data  (ro_data),
        .reg_q    (reg_q),
        .wr_strobe(wr_strobe),
        .rd_strobe(rd_strobe),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 sclk = ~sclk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Each bit is driven just after a rising edge and sampled on the next one.
    task automatic applyStimulus(input logic b);
        mosi = b;
        @(posedge sclk);
        #1;
    endtask

    task automatic startFrame(input logic rw_bit, input logic [6:0] addr);
        csn = 1'b0;
        applyStimulus(rw_bit);
        for (int i = 6; i >= 0; i--) applyStimulus(addr[i]);
    endtask

    task automatic sendWord(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) applyStimulus(w[i]);
    endtask

    task automatic readWord(output logic [7:0] w);
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w = {w[6:0], miso};
            if (i < 7) applyStimulus(1'b0);
        end
    endtask

    task automatic endFrame();
        csn = 1'b1;
        #1;
        @(posedge sclk);
        #1;
    endtask

    initial begin
        rstn    = 1'b0;
        csn     = 1'b1;
        mosi    = 1'b0;
        ro_data = '0;
        ro_data[120 +: 8] = 8'hC3;
        exp_q   = '0;
        repeat (2) @(posedge sclk);
        #1;
        checkOutput("rst_reg_q", reg_q, 128'h0);
        checkOutput("rst_miso", miso, 1'b0);
        checkOutput("rst_wr_strobe", wr_strobe, 16'h0);
        checkOutput("rst_rd_strobe", rd_strobe, 16'h0);
        checkOutput("rst_frame_err", frame_err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        @(posedge sclk);
        #1;

        // Write burst at address 3
        startFrame(1'b0, 7'd3);
        checkOutput("wr_busy", busy, 1'b1);
        sendWord(8'hA5);
        exp_q[24 +: 8] = 8'hA5;
        checkOutput("wr_strobe_w0", wr_strobe, 16'h0008);
        checkOutput("wr_reg_q_w0", reg_q, exp_q);
        applyStimulus(1'b0);
        checkOutput("wr_strobe_clear", wr_strobe, 16'h0000);
        for (int i = 6; i >= 0; i--) applyStimulus(rword_bit(8'h5A, i));
        exp_q[32 +: 8] = 8'h5A;
        checkOutput("wr_strobe_w1", wr_strobe, 16'h0010);
        checkOutput("wr_reg_q_w1", reg_q, exp_q);
        checkOutput("wr_frame_err", frame_err, 1'b0);
        endFrame();
        checkOutput("wr_busy_end", busy, 1'b0);

        // Preload register 14
        startFrame(1'b0, 7'd14);
        sendWord(8'h3C);
        exp_q[112 +: 8] = 8'h3C;
        checkOutput("pre14_strobe", wr_strobe, 16'h4000);
        checkOutput("pre14_reg_q", reg_q, exp_q);
        endFrame();

        // Read burst from 14 into the read-only register 15
        startFrame(1'b1, 7'd14);
        checkOutput("rd_strobe_14", rd_strobe, 16'h4000);
        readWord(rword);
        checkOutput("rd_word_14", rword, 8'h3C);
        applyStimulus(1'b0);
        checkOutput("rd_strobe_15", rd_strobe, 16'h8000);
        ro_data[120 +: 8] = 8'hFF;
        readWord(rword);
        checkOutput("rd_word_15", rword, 8'hC3);
        checkOutput("rd_frame_err", frame_err, 1'b0);
        endFrame();
        checkOutput("idle_miso_hold", miso, 1'b1);
        ro_data[120 +: 8] = 8'hC3;

        // Write to read-only register 15
        startFrame(1'b0, 7'd15);
        sendWord(8'h77);
        checkOutput("ro_wr_err", frame_err, 1'b1);
        checkOutput("ro_wr_strobe", wr_strobe, 16'h0000);
        endFrame();
        checkOutput("ro_err_sticky", frame_err, 1'b1);
        checkOutput("ro_reg_q", reg_q, exp_q);

        // Read out-of-range address 20
        csn = 1'b0;
        applyStimulus(1'b1);
        checkOutput("err_clear_first_edge", frame_err, 1'b0);
        for (int i = 6; i >= 0; i--) applyStimulus(rword_bit(8'd20, i));
        checkOutput("oor_rd_err", frame_err, 1'b1);
        checkOutput("oor_rd_strobe", rd_strobe, 16'h0000);
        readWord(rword);
        checkOutput("oor_rd_word", rword, 8'h00);
        endFrame();

        // Abort a write to register 2 after 5 data bits
        startFrame(1'b0, 7'd2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1);
        checkOutput("abort_strobe", wr_strobe, 16'h0000);
        csn = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_reg_q", reg_q, exp_q);
        checkOutput("abort_frame_err", frame_err, 1'b0);
        @(posedge sclk);
        #1;

        // Address wrap from 127 to 0
        startFrame(1'b0, 7'd127);
        sendWord(8'h11);
        checkOutput("wrap_w0_err", frame_err, 1'b1);
        checkOutput("wrap_w0_strobe", wr_strobe, 16'h0000);
        sendWord(8'h22);
        exp_q[0 +: 8] = 8'h22;
        checkOutput("wrap_w1_strobe", wr_strobe, 16'h0001);
        checkOutput("wrap_w1_reg_q", reg_q, exp_q);
        endFrame();

        // Reset in the middle of a read of register 4 (5A)
        startFrame(1'b1, 7'd4);
        applyStimulus(1'b0);
        checkOutput("mid_rd_miso", miso, 1'b1);
        rstn = 1'b0;
        #1;
        exp_q = '0;
        checkOutput("mid_rst_reg_q", reg_q, exp_q);
        checkOutput("mid_rst_miso", miso, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_frame_err", frame_err, 1'b0);
        checkOutput("mid_rst_rd_strobe", rd_strobe, 16'h0000);
        csn = 1'b1;
        @(posedge sclk);
        #1;
        rstn = 1'b1;
        @(posedge sclk);
        #1;

        // Fresh frame after reset: write then read back register 5
        startFrame(1'b0, 7'd5);
        sendWord(8'h96);
        exp_q[40 +: 8] = 8'h96;
        checkOutput("post_rst_strobe", wr_strobe, 16'h0020);
        checkOutput("post_rst_reg_q", reg_q, exp_q);
        endFrame();
        startFrame(1'b1, 7'd5);
        checkOutput("post_rst_rd_strobe", rd_strobe, 16'h0020);
        readWord(rword);
        checkOutput("post_rst_rd_word", rword, 8'h96);
        endFrame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic rword_bit(input logic [7:0] w, input int idx);
        return w[idx];
    endfunction

endmodule
